bicubic_lane_sync: RTL and testbench

BICUBIC_LANE_SYNC -- requirements
Module: bicubic_lane_sync

---
 rtl/bicubic_lane_sync_if.sv | 35 +++
 rtl/bicubic_lane_sync.sv | 130 +++++++++++++
 tb/tb_bicubic_lane_sync.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bicubic_lane_sync_if.sv
// Handshake bundle between the bicubic window source, the per-channel interpolation lanes
// and the joined-result sink.
interface bicubic_lane_sync_if #(
  parameter int unsigned NCH           = 3,
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned NPIX          = 16,
  parameter int unsigned NOUT          = 4
);
  logic                              bf_req_valid;
  logic                              bcci_req_ready;
  logic [NPIX*NCH*CHANNEL_WIDTH-1:0] bf_req_data;
  logic [NCH-1:0]                    lane_req_valid;
  logic [NCH-1:0]                    lane_req_ready;
  logic [NCH*NPIX*CHANNEL_WIDTH-1:0] lane_req_data;
  logic [NCH-1:0]                    lane_rsp_valid;
  logic [NCH-1:0]                    lane_rsp_ready;
  logic [NCH*NOUT*CHANNEL_WIDTH-1:0] lane_rsp_data;
  logic                              bcci_rsp_valid;
  logic                              bf_rsp_ready;
  logic [NOUT*NCH*CHANNEL_WIDTH-1:0] bcci_rsp_data;

  modport slave (
    input  bf_req_valid, bf_req_data, lane_req_ready, lane_rsp_valid, lane_rsp_data,
           bf_rsp_ready,
    output bcci_req_ready, lane_req_valid, lane_req_data, lane_rsp_ready, bcci_rsp_valid,
           bcci_rsp_data
  );

  modport master (
    output bf_req_valid, bf_req_data, lane_req_ready, lane_rsp_valid, lane_rsp_data,
           bf_rsp_ready,
    input  bcci_req_ready, lane_req_valid, lane_req_data, lane_rsp_ready, bcci_rsp_valid,
           bcci_rsp_data
  );
endinterface

// File: rtl/bicubic_lane_sync.sv
// Forks each pixel window out to NCH single-channel lanes and rejoins the lane results
// through per-lane FIFOs, counting joined beats per frame.
module bicubic_lane_sync #(
  parameter int unsigned NCH           = 3,
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned NPIX          = 16,
  parameter int unsigned NOUT          = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned FRAME_BEATS   = 4876,
  localparam int unsigned CW           = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  bicubic_lane_sync_if.slave  bus,
  output logic [CW-1:0]       beat_cnt,
  output logic                frame_done
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = NOUT * CHANNEL_WIDTH;

  typedef logic [AW:0] ptr_t;

  logic [NCH-1:0] sent_q, sent_d, lane_hs;
  logic           req_hs;

  ptr_t           wptr_q [NCH];
  ptr_t           wptr_d [NCH];
  ptr_t           rptr_q [NCH];
  ptr_t           rptr_d [NCH];
  logic [RW-1:0]  mem_q  [NCH][DEPTH];
  logic [NCH-1:0] full, empty, push;
  logic           pop;

  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           frame_done_q, frame_done_d;

  // Fork: channel-major lanes are a pure re-slicing of the pixel-major window.
  always_comb begin
    bus.lane_req_data = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int p = 0; p < NPIX; p++) begin
        bus.lane_req_data[(c*NPIX+p)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          bus.bf_req_data[(p*NCH+NCH-1-c)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
    end
  end

  assign bus.lane_req_valid = {NCH{bus.bf_req_valid}} & ~sent_q;
  assign lane_hs            = bus.lane_req_valid & bus.lane_req_ready;
  assign bus.bcci_req_ready = &(sent_q | bus.lane_req_ready);
  assign req_hs             = bus.bf_req_valid & bus.bcci_req_ready;
  assign sent_d             = req_hs ? '0 : (sent_q | lane_hs);

  // Join: extra pointer MSB tells full from empty when the index bits match.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < NCH; c++) begin
      full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                 (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
      empty[c] = (wptr_q[c] == rptr_q[c]);
    end
  end

  assign bus.lane_rsp_ready = ~full;
  assign push               = bus.lane_rsp_valid & ~full;
  assign bus.bcci_rsp_valid = ~|empty;
  assign pop                = bus.bcci_rsp_valid & bus.bf_rsp_ready;

  always_comb begin
    bus.bcci_rsp_data = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j < NOUT; j++) begin
        bus.bcci_rsp_data[(j*NCH+NCH-1-c)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          mem_q[c][rptr_q[c][AW-1:0]][j*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wptr_d[c] = wptr_q[c] + ptr_t'(push[c]);
      rptr_d[c] = rptr_q[c] + ptr_t'(pop);
    end
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    if (pop) begin
      if (beat_cnt_q == CW'(FRAME_BEATS - 1)) begin
        beat_cnt_d   = '0;
        frame_done_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q       <= '0;
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      sent_q       <= sent_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem_q[c][wptr_q[c][AW-1:0]] <= bus.lane_rsp_data[c*RW +: RW];
    end
  end

  assign beat_cnt   = beat_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bicubic_lane_sync.sv
// Randomised bench for bicubic_lane_sync with a queue-based reference model and directed
// scenarios for lane skew, backpressure, frame wrap and mid-frame reset.
module tb_bicubic_lane_sync;
  localparam int NCH   = 3;
  localparam int CWD   = 8;
  localparam int NPIX  = 16;
  localparam int NOUT  = 4;
  localparam int DEPTH = 4;
  localparam int FB    = 5;
  localparam int BW    = NPIX * NCH * CWD;
  localparam int LW    = NCH * NPIX * CWD;
  localparam int RW    = NOUT * CWD;
  localparam int RSPW  = NOUT * NCH * CWD;
  localparam int PW    = NCH * CWD;

  logic       clk;
  logic       rst_n;
  logic [2:0] beat_cnt;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  bicubic_lane_sync_if #(.NCH(NCH), .CHANNEL_WIDTH(CWD), .NPIX(NPIX), .NOUT(NOUT)) bus ();

  bicubic_lane_sync #(
    .NCH(NCH), .CHANNEL_WIDTH(CWD), .NPIX(NPIX), .NOUT(NOUT), .DEPTH(DEPTH),
    .FRAME_BEATS(FB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .beat_cnt(beat_cnt),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: windows counted per lane, lane results held in plain queues.
  int            win_idx;
  int            lane_cnt [NCH];
  logic [RW-1:0] fq [NCH][$];
  int            beats_total;
  bit            fd_exp;

  function automatic bit exp_req_ready();
    for (int c = 0; c < NCH; c++)
      if (lane_cnt[c] == win_idx && !bus.lane_req_ready[c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_rsp_valid();
    for (int c = 0; c < NCH; c++) if (fq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [LW-1:0] exp_lane_data(input logic [BW-1:0] win);
    logic [CWD-1:0] pix [NPIX][NCH];
    logic [LW-1:0]  r;
    r = '0;
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < NCH; c++)
        pix[p][c] = CWD'(win >> (p*PW + (NCH-1-c)*CWD));
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < NPIX; p++)
        r = r | (LW'(pix[p][c]) << ((c*NPIX + p)*CWD));
    return r;
  endfunction

  function automatic logic [RSPW-1:0] exp_rsp_data();
    logic [RSPW-1:0] r;
    logic [PW-1:0]   pixv;
    logic [RW-1:0]   h;
    r = '0;
    for (int j = 0; j < NOUT; j++) begin
      pixv = '0;
      for (int c = 0; c < NCH; c++) begin
        h    = fq[c][0];
        pixv = (pixv << CWD) | PW'(CWD'(h >> (j*CWD)));
      end
      r = r | (RSPW'(pixv) << (j*PW));
    end
    return r;
  endfunction

  task automatic model_reset();
    win_idx     = 0;
    beats_total = 0;
    fd_exp      = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      lane_cnt[c] = 0;
      fq[c].delete();
    end
  endtask

  task automatic model_step();
    bit            acc, pop;
    bit [NCH-1:0]  psh;
    logic [RW-1:0] tmp;
    acc = bus.bf_req_valid && exp_req_ready();
    pop = exp_rsp_valid() && bus.bf_rsp_ready;
    for (int c = 0; c < NCH; c++)
      psh[c] = bus.lane_rsp_valid[c] && (fq[c].size() < DEPTH);
    if (acc) begin
      win_idx++;
      for (int c = 0; c < NCH; c++) lane_cnt[c] = win_idx;
    end else if (bus.bf_req_valid) begin
      for (int c = 0; c < NCH; c++)
        if (lane_cnt[c] == win_idx && bus.lane_req_ready[c]) lane_cnt[c]++;
    end
    fd_exp = pop && (beats_total % FB == FB - 1);
    if (pop) begin
      beats_total++;
      for (int c = 0; c < NCH; c++) tmp = fq[c].pop_front();
    end
    for (int c = 0; c < NCH; c++)
      if (psh[c]) fq[c].push_back(bus.lane_rsp_data[c*RW +: RW]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    logic [NCH-1:0] lrv_e, rr_e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < NCH; c++) begin
          lrv_e[c] = bus.bf_req_valid && (lane_cnt[c] == win_idx);
          rr_e[c]  = fq[c].size() < DEPTH;
        end
        check("lane_req_valid", bus.lane_req_valid, lrv_e);
        check("bcci_req_ready", bus.bcci_req_ready, exp_req_ready());
        if (bus.bf_req_valid) check("lane_req_data", bus.lane_req_data, exp_lane_data(bus.bf_req_data));
        check("lane_rsp_ready", bus.lane_rsp_ready, rr_e);
        check("bcci_rsp_valid", bus.bcci_rsp_valid, exp_rsp_valid());
        if (exp_rsp_valid()) check("bcci_rsp_data", bus.bcci_rsp_data, exp_rsp_data());
        check("beat_cnt", beat_cnt, beats_total % FB);
        check("frame_done", frame_done, fd_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] lane_word(input int c, input int k);
    logic [RW-1:0] w;
    w = '0;
    for (int j = 0; j < NOUT; j++) w[j*CWD +: CWD] = CWD'(c*64 + k*4 + j);
    return w;
  endfunction

  function automatic logic [BW-1:0] rand_window();
    logic [BW-1:0] w;
    for (int i = 0; i < BW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  localparam logic [RSPW-1:0] FIRST_BEAT = 96'h034383_024282_014181_004080;

  initial begin
    int cyc;
    int shown_idx;
    int out_pct;
    rst_n              = 1'b1;
    bus.bf_req_valid   = 1'b0;
    bus.bf_req_data    = '0;
    bus.lane_req_ready = '0;
    bus.lane_rsp_valid = '0;
    bus.lane_rsp_data  = '0;
    bus.bf_rsp_ready   = 1'b0;
    #1 rst_n = 1'b0;
    bus.bf_req_valid = 1'b1;
    #2;
    check("rst_rsp_valid", bus.bcci_rsp_valid, 1'b0);
    check("rst_lane_rsp_ready", bus.lane_rsp_ready, 3'b111);
    check("rst_lane_req_valid", bus.lane_req_valid, 3'b111);
    check("rst_beat_cnt", beat_cnt, 3'd0);
    check("rst_frame_done", frame_done, 1'b0);
    bus.bf_req_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;

    // Fork with lane 2 three cycles late.
    step();
    bus.bf_req_data    = {NPIX{24'h112233}};
    bus.bf_req_valid   = 1'b1;
    bus.lane_req_ready = 3'b011;
    #2;
    check("fork_ready_low", bus.bcci_req_ready, 1'b0);
    check("fork_lane2_data", bus.lane_req_data[LW-1 -: NPIX*CWD], {NPIX{8'h33}});
    check("fork_lane0_data", bus.lane_req_data[NPIX*CWD-1:0], {NPIX{8'h11}});
    repeat (2) begin
      step();
      #2;
      check("fork_lane2_pending", bus.lane_req_valid, 3'b100);
      check("fork_ready_wait", bus.bcci_req_ready, 1'b0);
    end
    step();
    bus.lane_req_ready = 3'b111;
    #2;
    check("fork_ready_rise", bus.bcci_req_ready, 1'b1);
    check("fork_only_lane2", bus.lane_req_valid, 3'b100);
    step();
    bus.bf_req_valid   = 1'b0;
    bus.lane_req_ready = '0;

    // Join with lane 0 four results ahead.
    for (int k = 0; k < 4; k++) begin
      step();
      bus.lane_rsp_valid = 3'b001;
      bus.lane_rsp_data  = {64'h0, lane_word(0, k)};
    end
    step();
    bus.lane_rsp_data = {64'h0, lane_word(0, 15)};
    #2;
    check("join_lane0_full", bus.lane_rsp_ready, 3'b110);
    check("join_not_valid", bus.bcci_rsp_valid, 1'b0);
    step();
    bus.lane_rsp_valid = 3'b110;
    bus.lane_rsp_data  = {lane_word(2, 0), lane_word(1, 0), 32'h0};
    #2;
    check("join_latency", bus.bcci_rsp_valid, 1'b0);
    step();
    bus.lane_rsp_valid = '0;
    #2;
    check("join_valid", bus.bcci_rsp_valid, 1'b1);
    check("join_first_beat", bus.bcci_rsp_data, FIRST_BEAT);

    // Fill every FIFO, then hold the sink off for 10 cycles.
    for (int k = 1; k < 4; k++) begin
      step();
      bus.lane_rsp_valid = 3'b110;
      bus.lane_rsp_data  = {lane_word(2, k), lane_word(1, k), 32'h0};
    end
    step();
    bus.lane_rsp_valid = 3'b111;
    for (int i = 0; i < 10; i++) begin
      bus.lane_rsp_data = {$urandom, $urandom, $urandom};
      step();
      #2;
      check("bp_ready_low", bus.lane_rsp_ready, 3'b000);
      check("bp_data_hold", bus.bcci_rsp_data, FIRST_BEAT);
    end

    // Five handshakes wrap a 5-beat frame.
    check("frame_start", beat_cnt, 3'd0);
    bus.bf_rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      bus.lane_rsp_data = {$urandom, $urandom, $urandom};
      if (i == 5) bus.bf_rsp_ready = 1'b0;
      #2;
      check("frame_beat_cnt", beat_cnt, i % 5);
      check("frame_done_seq", frame_done, i == 5);
    end
    step();
    #2;
    check("frame_done_single", frame_done, 1'b0);

    // Async reset at beat_cnt 3 with a partially forked window.
    bus.lane_rsp_valid = '0;
    bus.bf_rsp_ready   = 1'b1;
    bus.bf_req_valid   = 1'b1;
    bus.bf_req_data    = rand_window();
    bus.lane_req_ready = 3'b001;
    repeat (3) step();
    bus.bf_rsp_ready   = 1'b0;
    bus.lane_req_ready = '0;
    #2;
    check("pre_reset_cnt", beat_cnt, 3'd3);
    check("pre_reset_sent", bus.lane_req_valid, 3'b110);
    rst_n = 1'b0;
    #1;
    check("reset_cnt", beat_cnt, 3'd0);
    check("reset_rsp_valid", bus.bcci_rsp_valid, 1'b0);
    check("reset_sent_clear", bus.lane_req_valid, 3'b111);
    check("reset_rsp_ready", bus.lane_rsp_ready, 3'b111);
    step();
    #2 rst_n = 1'b1;
    bus.bf_req_valid = 1'b0;
    step();
    #2;
    check("post_reset_empty", bus.bcci_rsp_valid, 1'b0);

    // Random traffic until 1000 joined beats.
    cyc       = 0;
    shown_idx = win_idx;
    while (beats_total < 1000 && cyc < 6000) begin
      step();
      cyc++;
      if (bus.bf_req_valid) begin
        if (win_idx != shown_idx) begin
          bus.bf_req_valid = ($urandom_range(0, 3) != 0);
          bus.bf_req_data  = rand_window();
          shown_idx        = win_idx;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        bus.bf_req_valid = 1'b1;
        bus.bf_req_data  = rand_window();
        shown_idx        = win_idx;
      end
      bus.lane_req_ready = 3'($urandom);
      for (int c = 0; c < NCH; c++)
        bus.lane_rsp_valid[c] = ($urandom_range(0, 99) < 60 + 15*c);
      bus.lane_rsp_data = {$urandom, $urandom, $urandom};
      out_pct           = ((cyc / 100) % 2 == 1) ? 90 : 40;
      bus.bf_rsp_ready  = ($urandom_range(0, 99) < out_pct);
    end
    check("random_beats_reached", beats_total >= 1000, 1'b1);

    bus.bf_req_valid   = 1'b0;
    bus.lane_req_ready = '0;
    bus.lane_rsp_valid = '0;
    bus.bf_rsp_ready   = 1'b0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
